// File: rtl/audio_match_pkg.sv
// Shared definitions for the audio template matcher.
// Holds the scoring FSM state encoding, the match threshold used when
// AUDIO_MATCHER_THRESH_EN is defined, and width helpers for the address,
// template-select and accumulator buses.
package audio_match_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMPARE,
        DONE
    } state_e;

    // Width of an index that must count 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Smallest width that holds the worst-case SAD: every sample at full-scale difference.
    function automatic int acc_width(input int samples, input int dw);
        return $clog2(samples * ((1 << dw) - 1) + 1);
    endfunction

    localparam int ACC_W = acc_width(1000, 10);

    localparam logic [19:0] MATCH_THRESH = 20'd40000;

endpackage

// File: rtl/audio_matcher_if.sv
// Bus between the matcher and its host.
// The host (master) issues start and returns the audio buffer and template ROM
// words; the matcher (slave) drives the shared sample address, the template
// bank select, busy/done status, and the best-match result.
interface audio_matcher_if #(
    parameter int SAMPLES   = 1000,
    parameter int TEMPLATES = 4,
    parameter int DW        = 10
) ();

    localparam int AW    = audio_match_pkg::idx_width(SAMPLES);
    localparam int TW    = audio_match_pkg::idx_width(TEMPLATES);
    localparam int ACC_W = audio_match_pkg::acc_width(SAMPLES, DW);

    logic             start;
    logic [AW-1:0]    addr;
    logic [TW-1:0]    tmpl_sel;
    logic [DW-1:0]    audio_data;
    logic [DW-1:0]    tmpl_data;
    logic             busy;
    logic             done;
    logic [TW-1:0]    match_idx;
    logic [ACC_W-1:0] match_score;
    logic             match_valid;

    modport master (
        output start, audio_data, tmpl_data,
        input  addr, tmpl_sel, busy, done, match_idx, match_score, match_valid
    );

    modport slave (
        input  start, audio_data, tmpl_data,
        output addr, tmpl_sel, busy, done, match_idx, match_score, match_valid
    );

endinterface

// File: rtl/sad_accumulator.sv
// Sum-of-absolute-differences datapath for one template pass.
// Ports: clk, reset (async active-low), clear (zero the pipeline and sum),
// enable (a/b hold a valid sample pair this cycle), a/b (audio and template
// words), acc (running SAD).
// The absolute difference is registered first and added one cycle later, so
// acc lags the last valid pair by two cycles.
module sad_accumulator #(
    parameter int DW    = 10,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] acc
);

    logic [DW-1:0]    diff_q, diff_d;
    logic             diff_vld_q, diff_vld_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        diff_d     = (a >= b) ? (a - b) : (b - a);
        diff_vld_d = enable;
        acc_d      = acc_q;
        if (diff_vld_q) begin
            acc_d = acc_q + ACC_W'(diff_q);
        end
        if (clear) begin
            diff_d     = '0;
            diff_vld_d = 1'b0;
            acc_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            diff_q     <= '0;
            diff_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            diff_q     <= diff_d;
            diff_vld_q <= diff_vld_d;
            acc_q      <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/audio_matcher.sv
// Scores a captured utterance against TEMPLATES stored templates by SAD and
// reports the lowest-scoring template (ties go to the lowest index).
// Ports: clk, reset (async active-low), bus (audio_matcher_if slave:
// start, addr, tmpl_sel, audio_data, tmpl_data, busy, done, match_idx,
// match_score, match_valid).
// Optional macro AUDIO_MATCHER_THRESH_EN: match_valid reports whether the best
// score is within MATCH_THRESH; otherwise match_valid is always 1 at done.
module audio_matcher
    import audio_match_pkg::*;
#(
    parameter int SAMPLES   = 1000,
    parameter int TEMPLATES = 4,
    parameter int DW        = 10
) (
    input logic            clk,
    input logic            reset,
    audio_matcher_if.slave bus
);

    localparam int AW      = idx_width(SAMPLES);
    localparam int TW      = idx_width(TEMPLATES);
    localparam int SCORE_W = acc_width(SAMPLES, DW);

    state_e             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [TW-1:0]      tmpl_sel_q, tmpl_sel_d;
    logic               drain_cnt_q, drain_cnt_d;
    logic               rd_valid_q, rd_valid_d;
    logic [SCORE_W-1:0] best_score_q, best_score_d;
    logic [TW-1:0]      best_idx_q, best_idx_d;
    logic [TW-1:0]      match_idx_q, match_idx_d;
    logic [SCORE_W-1:0] match_score_q, match_score_d;
    logic               match_valid_q, match_valid_d;
    logic               acc_clear;
    logic [SCORE_W-1:0] acc;
    logic [SCORE_W-1:0] cand_score;
    logic [TW-1:0]      cand_idx;

    // rd_valid_q marks the cycle when the ROM/buffer words for a FETCH address arrive.
    sad_accumulator #(
        .DW    (DW),
        .ACC_W (SCORE_W)
    ) u_sad (
        .clk    (clk),
        .reset  (reset),
        .clear  (acc_clear),
        .enable (rd_valid_q),
        .a      (bus.audio_data),
        .b      (bus.tmpl_data),
        .acc    (acc)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        tmpl_sel_d    = tmpl_sel_q;
        drain_cnt_d   = drain_cnt_q;
        rd_valid_d    = (state_q == FETCH);
        best_score_d  = best_score_q;
        best_idx_d    = best_idx_q;
        match_idx_d   = match_idx_q;
        match_score_d = match_score_q;
        match_valid_d = match_valid_q;
        acc_clear     = 1'b0;

        // Strict less-than keeps the earlier (lower) template on a tie.
        cand_score = best_score_q;
        cand_idx   = best_idx_q;
        if (acc < best_score_q) begin
            cand_score = acc;
            cand_idx   = tmpl_sel_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = FETCH;
                    addr_d       = '0;
                    tmpl_sel_d   = '0;
                    best_score_d = '1;
                    best_idx_d   = '0;
                    acc_clear    = 1'b1;
                end
            end
            FETCH: begin
                if (addr_q == AW'(SAMPLES - 1)) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            // Two cycles let the read latency and the difference register empty into acc.
            DRAIN: begin
                if (drain_cnt_q) begin
                    state_d = COMPARE;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            COMPARE: begin
                best_score_d = cand_score;
                best_idx_d   = cand_idx;
                if (tmpl_sel_q != TW'(TEMPLATES - 1)) begin
                    state_d    = FETCH;
                    tmpl_sel_d = tmpl_sel_q + 1'b1;
                    addr_d     = '0;
                    acc_clear  = 1'b1;
                end else begin
                    // Results are latched here so they are already valid while done is high.
                    state_d       = DONE;
                    match_idx_d   = cand_idx;
                    match_score_d = cand_score;
`ifdef AUDIO_MATCHER_THRESH_EN
                    match_valid_d = (cand_score <= SCORE_W'(MATCH_THRESH));
`else
                    match_valid_d = 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            tmpl_sel_q    <= '0;
            drain_cnt_q   <= 1'b0;
            rd_valid_q    <= 1'b0;
            best_score_q  <= '1;
            best_idx_q    <= '0;
            match_idx_q   <= '0;
            match_score_q <= '0;
            match_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            tmpl_sel_q    <= tmpl_sel_d;
            drain_cnt_q   <= drain_cnt_d;
            rd_valid_q    <= rd_valid_d;
            best_score_q  <= best_score_d;
            best_idx_q    <= best_idx_d;
            match_idx_q   <= match_idx_d;
            match_score_q <= match_score_d;
            match_valid_q <= match_valid_d;
        end
    end

    assign bus.addr        = addr_q;
    assign bus.tmpl_sel    = tmpl_sel_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.match_idx   = match_idx_q;
    assign bus.match_score = match_score_q;
    assign bus.match_valid = match_valid_q;

endmodule

// File: tb/tb_audio_matcher.sv
// Testbench for audio_matcher: models the audio buffer and template ROM with
// one-cycle read latency, fills them with directed and random patterns, and
// compares each run against a reference that computes every template's SAD
// directly and picks the lowest (first on ties).
module tb_audio_matcher;
    import audio_match_pkg::*;

    localparam int SAMPLES   = 1000;
    localparam int TEMPLATES = 4;
    localparam int DW        = 10;
    localparam int SCORE_W   = acc_width(SAMPLES, DW);
    localparam int BUDGET    = 5000;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    audio_matcher_if #(.SAMPLES(SAMPLES), .TEMPLATES(TEMPLATES), .DW(DW)) bus ();

    audio_matcher #(.SAMPLES(SAMPLES), .TEMPLATES(TEMPLATES), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] audio_mem [SAMPLES];
    logic [DW-1:0] tmpl_mem  [TEMPLATES][SAMPLES];

    // Synchronous-read memories: the word for an address appears one cycle later.
    always @(posedge clk) begin
        bus.audio_data <= audio_mem[bus.addr];
        bus.tmpl_data  <= tmpl_mem[bus.tmpl_sel][bus.addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain SAD per template, lowest wins, earlier index wins ties.
    task automatic compute_expected(output int exp_idx, output int exp_score);
        int best;
        best    = (1 << SCORE_W) - 1;
        exp_idx = 0;
        for (int t = 0; t < TEMPLATES; t++) begin
            int sad;
            sad = 0;
            for (int s = 0; s < SAMPLES; s++) begin
                int a, b;
                a = int'(audio_mem[s]);
                b = int'(tmpl_mem[t][s]);
                sad += (a > b) ? (a - b) : (b - a);
            end
            if (sad < best) begin
                best    = sad;
                exp_idx = t;
            end
        end
        exp_score = best;
    endtask

    task automatic fill_random();
        for (int s = 0; s < SAMPLES; s++) begin
            audio_mem[s] = DW'($urandom);
            for (int t = 0; t < TEMPLATES; t++) tmpl_mem[t][s] = DW'($urandom);
        end
    endtask

    // One scoring run. abort_at>0 pulls reset low at that cycle; inject pulses
    // start during FETCH and during DONE.
    task automatic apply_stimulus(input string name, input int abort_at, input bit inject);
        int  exp_idx, exp_score, n;
        bit  seen, extra, exp_valid;
        compute_expected(exp_idx, exp_score);
`ifdef AUDIO_MATCHER_THRESH_EN
        exp_valid = (exp_score <= 40000);
`else
        exp_valid = 1'b1;
`endif
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (n < BUDGET && !seen) begin
            if (inject) bus.start = (n == 100);
            if (abort_at > 0 && n == abort_at) begin
                reset = 1'b0;
                #1;
                check_output({name, "_rst_addr"},  32'(bus.addr), 0);
                check_output({name, "_rst_tsel"},  32'(bus.tmpl_sel), 0);
                check_output({name, "_rst_busy"},  32'(bus.busy), 0);
                check_output({name, "_rst_done"},  32'(bus.done), 0);
                check_output({name, "_rst_idx"},   32'(bus.match_idx), 0);
                check_output({name, "_rst_score"}, 32'(bus.match_score), 0);
                check_output({name, "_rst_valid"}, 32'(bus.match_valid), 0);
                extra = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (bus.done !== 1'b0) extra = 1'b1;
                end
                @(posedge clk); #1 reset = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra = 1'b1;
                end
                check_output({name, "_no_activity_after_abort"}, 32'(extra), 0);
                return;
            end
            @(negedge clk);
            if (n == 10) check_output({name, "_busy_mid"}, 32'(bus.busy), 1);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        check_output({name, "_done_seen"},  32'(seen), 1);
        check_output({name, "_done_cycle"}, 32'(n + 1), 32'(TEMPLATES * (SAMPLES + 3) + 1));
        check_output({name, "_idx"},        32'(bus.match_idx), 32'(exp_idx));
        check_output({name, "_score"},      32'(bus.match_score), 32'(exp_score));
        check_output({name, "_valid"},      32'(bus.match_valid), 32'(exp_valid));
        if (inject) bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        extra = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra = 1'b1;
        end
        check_output({name, "_quiet_after_done"}, 32'(extra), 0);
    endtask

    initial begin
        int a, k;
        bus.start = 1'b0;
        fill_random();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_busy",  32'(bus.busy), 0);
        check_output("reset_done",  32'(bus.done), 0);
        check_output("reset_addr",  32'(bus.addr), 0);
        check_output("reset_tsel",  32'(bus.tmpl_sel), 0);
        check_output("reset_idx",   32'(bus.match_idx), 0);
        check_output("reset_score", 32'(bus.match_score), 0);
        check_output("reset_valid", 32'(bus.match_valid), 0);
        @(posedge clk); #1 reset = 1'b1;

        $display("[TB] exact match on template 2");
        for (int s = 0; s < SAMPLES; s++) begin
            a = int'($urandom_range(1018, 5));
            audio_mem[s] = DW'(a);
            for (int t = 0; t < TEMPLATES; t++)
                tmpl_mem[t][s] = (t == 2) ? DW'(a) : (($urandom % 2) != 0 ? DW'(a + 5) : DW'(a - 5));
        end
        apply_stimulus("exact", 0, 1'b0);
        check_output("exact_idx_const",   32'(bus.match_idx), 2);
        check_output("exact_score_const", 32'(bus.match_score), 0);

        $display("[TB] tie between templates 1 and 3");
        for (int s = 0; s < SAMPLES; s++) begin
            a = int'($urandom_range(1020, 0));
            audio_mem[s]   = DW'(a);
            tmpl_mem[0][s] = DW'(a + 2);
            tmpl_mem[1][s] = DW'(a + 1);
            tmpl_mem[2][s] = DW'(a + 3);
            tmpl_mem[3][s] = DW'(a + 1);
        end
        apply_stimulus("tie", 0, 1'b0);
        check_output("tie_idx_const",   32'(bus.match_idx), 1);
        check_output("tie_score_const", 32'(bus.match_score), 1000);

        $display("[TB] full-scale difference");
        for (int s = 0; s < SAMPLES; s++) begin
            audio_mem[s] = '1;
            for (int t = 0; t < TEMPLATES; t++) tmpl_mem[t][s] = '0;
        end
        apply_stimulus("fullscale", 0, 1'b0);
        check_output("fullscale_score_const", 32'(bus.match_score), 1023000);

        $display("[TB] best score just under and just over the threshold");
        for (int pass = 0; pass < 2; pass++) begin
            k = int'($urandom_range(SAMPLES - 1, 0));
            for (int s = 0; s < SAMPLES; s++) begin
                a = int'($urandom_range(900, 0));
                audio_mem[s]   = DW'(a);
                tmpl_mem[0][s] = (s == k) ? DW'(a + 40 + ((pass == 0) ? -1 : 1)) : DW'(a + 40);
                for (int t = 1; t < TEMPLATES; t++) tmpl_mem[t][s] = DW'(a + 100);
            end
            apply_stimulus((pass == 0) ? "thresh_lo" : "thresh_hi", 0, 1'b0);
            check_output("thresh_score_const", 32'(bus.match_score), (pass == 0) ? 39999 : 40001);
        end

        $display("[TB] random data with stray start pulses");
        fill_random();
        apply_stimulus("rand_inject", 0, 1'b1);

        $display("[TB] reset mid-run then fresh run");
        fill_random();
        apply_stimulus("abort", 1500, 1'b0);
        fill_random();
        apply_stimulus("after_abort", 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
